// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: function codes, FSM states
// and iteration constants.
package muldiv_pkg;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MADD  = 6'b011100;
  localparam logic [5:0] OP_MADDU = 6'b011101;

  localparam int          ITER    = 32;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// shift-subtract for divide, on the partial pair {acc, q}.
module muldiv_step (
  input  logic        div,
  input  logic [31:0] acc,
  input  logic [31:0] q,
  input  logic [31:0] m,
  output logic [31:0] acc_next,
  output logic [31:0] q_next
);

  logic [32:0] sum;
  logic [32:0] rem;
  logic [32:0] diff;

  always_comb begin
    sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : 33'd0);
    rem  = {acc, q[31]};
    // rem < 2*m always holds, so bit 32 of the difference is the borrow
    diff = rem - {1'b0, m};
    if (div) begin
      if (!diff[32]) begin
        acc_next = diff[31:0];
        q_next   = {q[30:0], 1'b1};
      end else begin
        acc_next = rem[31:0];
        q_next   = {q[30:0], 1'b0};
      end
    end else begin
      acc_next = sum[32:1];
      q_next   = {sum[0], q[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the Hi/Lo pair; 33 busy cycles per
// MULT/MADD/DIV, single-edge MTHI/MTLO.
//
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO write here
//   RUN   | 32 magnitude iterations, Hi/Lo untouched
//   FIX   | sign correction, Hi/Lo write, done next cycle
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state, state_next;
  logic [4:0]  count;
  logic [31:0] acc, q, m, a_raw;
  logic        is_div, is_madd, neg_res, neg_rem, div0;

  logic        iter_op, div_op, madd_op, signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] acc_next, q_next;
  logic [63:0] prod, sum64;
  logic [31:0] hi_fix, lo_fix;

  always_comb begin
    iter_op   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
                (op == OP_DIVU) || (op == OP_MADD)  || (op == OP_MADDU);
    div_op    = (op == OP_DIV)  || (op == OP_DIVU);
    madd_op   = (op == OP_MADD) || (op == OP_MADDU);
    signed_op = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    a_neg     = signed_op && a[31];
    b_neg     = signed_op && b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
  end

  muldiv_step u_step (
    .div      (is_div),
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  always_comb begin
    prod  = neg_res ? (~{acc, q} + 64'd1) : {acc, q};
    sum64 = {hi, lo} + prod;
    if (is_div) begin
      if (div0) begin
        hi_fix = a_raw;
        lo_fix = DIV0_LO;
      end else begin
        hi_fix = neg_rem ? (~acc + 32'd1) : acc;
        lo_fix = neg_res ? (~q + 32'd1) : q;
      end
    end else if (is_madd) begin
      hi_fix = sum64[63:32];
      lo_fix = sum64[31:0];
    end else begin
      hi_fix = prod[63:32];
      lo_fix = prod[31:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && iter_op) state_next = RUN;
      RUN:     if (count == 5'(ITER - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      is_madd <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (start && iter_op) begin
            count   <= '0;
            acc     <= '0;
            q       <= div_op ? a_mag : b_mag;
            m       <= div_op ? b_mag : a_mag;
            a_raw   <= a;
            is_div  <= div_op;
            is_madd <= madd_op;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= (b == 32'd0);
          end else if (start && op == OP_MTHI) begin
            hi <= a;
          end else if (start && op == OP_MTLO) begin
            lo <= a;
          end
        end
        RUN: begin
          acc   <= acc_next;
          q     <= q_next;
          count <= count + 5'd1;
        end
        FIX: begin
          hi <= hi_fix;
          lo <= lo_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations compared against an arithmetic model of Hi/Lo.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [5:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi = '0, mlo = '0;

  muldiv_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: architectural effect of one accepted operation on Hi/Lo
  task automatic model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    logic [63:0]     hl;
    int              sx, sy;
    hl = {mhi, mlo};
    sp = longint'($signed(x)) * longint'($signed(y));
    up = longint'({32'd0, x}) * longint'({32'd0, y});
    sx = $signed(x);
    sy = $signed(y);
    case (f)
      OP_MTHI:  mhi = x;
      OP_MTLO:  mlo = x;
      OP_MULT:  {mhi, mlo} = sp;
      OP_MULTU: {mhi, mlo} = up;
      OP_MADD:  {mhi, mlo} = hl + 64'(sp);
      OP_MADDU: {mhi, mlo} = hl + 64'(up);
      OP_DIV: begin
        if (y == 0) begin mlo = 32'hFFFF_FFFF; mhi = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin mlo = x; mhi = 0; end
        else begin mlo = sx / sy; mhi = sx % sy; end
      end
      OP_DIVU: begin
        if (y == 0) begin mlo = 32'hFFFF_FFFF; mhi = x; end
        else begin mlo = x / y; mhi = x % y; end
      end
      default: ;
    endcase
  endtask

  function automatic bit is_iter(input logic [5:0] f);
    return f inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU};
  endfunction

  // Issue one op from IDLE; ignore_at >= 0 pulses an MTLO at that busy cycle
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] x,
                        input logic [31:0] y, input int ignore_at);
    logic [31:0] old_hi, old_lo;
    bit          stable;
    int          cycles;
    start = 1'b1; op = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    model(f, x, y);
    if (!is_iter(f)) begin
      chk({tag, " hi"}, {32'd0, hi}, {32'd0, mhi});
      chk({tag, " lo"}, {32'd0, lo}, {32'd0, mlo});
      chk({tag, " busy"}, {63'd0, busy | done}, 64'd0);
      return;
    end
    old_hi = hi; old_lo = lo; stable = 1'b1; cycles = 0;
    while (busy && cycles < 60) begin
      if (hi !== old_hi || lo !== old_lo || done) stable = 1'b0;
      if (cycles == ignore_at) begin
        start = 1'b1; op = OP_MTLO; a = 32'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
    end
    chk({tag, " cycles"}, 64'(cycles), 64'd33);
    chk({tag, " hold"}, {63'd0, stable}, 64'd1);
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " hilo"}, {hi, lo}, {mhi, mlo});
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] ops [11];
    int         dcnt;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
            OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO, 6'b000000};
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {hi, lo}, 64'd0);
    chk("reset flags", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, -1);
    chk("mult_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    chk("div_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, -1);
    run_op("div_zero", OP_DIV, 32'hFFFF_FF00, 32'd0, -1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("mthi", OP_MTHI, 32'd0, 32'd0, -1);
    run_op("mtlo", OP_MTLO, 32'd10, 32'd0, -1);
    run_op("madd", OP_MADD, 32'd3, 32'd4, -1);
    chk("madd const", {hi, lo}, 64'd22);
    run_op("maddu", OP_MADDU, 32'hFFFF_FFFF, 32'd2, -1);
    run_op("mult_ignore", OP_MULT, 32'd1234, 32'hFFFF_0001, 10);
    // called while done is high: accepted back-to-back
    run_op("mult_b2b", OP_MULT, 32'd99, 32'd77, -1);
    @(posedge clk); #1;
    chk("done drop", {62'd0, busy, done}, 64'd0);

    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mhi = '0; mlo = '0;
    chk("rst_mid", {hi, lo}, 64'd0);
    chk("rst_mid flags", {62'd0, busy, done}, 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("rst_no_done", 64'(dcnt), 64'd0);

    for (int i = 0; i < 60; i++) begin
      logic [5:0] f;
      f = ops[$urandom_range(0, 10)];
      run_op($sformatf("rnd%0d", i), f, rnd_val(), rnd_val(), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
